// File: rtl/game_pkg.sv
// Shared game encodings: game states, facing directions, playfield limits and stage spawns.
// The player controller and the draw path both import this package.
package game_pkg;

    typedef enum logic [3:0] {
        ST_TITLE    = 4'd0,
        ST_STAFF    = 4'd1,
        ST_STAGE1   = 4'd2,
        ST_SUCCESS1 = 4'd3,
        ST_STAGE2   = 4'd4,
        ST_SUCCESS2 = 4'd5,
        ST_STAGE3   = 4'd6,
        ST_SUCCESS3 = 4'd7,
        ST_FAIL     = 4'd8
    } game_state_t;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_QUERY = 2'd1,
        FSM_MOVE  = 2'd2
    } move_state_t;

    localparam int TILE     = 10;
    localparam int X_MAX    = 310;
    localparam int Y_MAX    = 230;
    localparam int ANIM_DIV = 4;

    localparam logic [8:0] STAGE1_X = 9'd20;
    localparam logic [8:0] STAGE1_Y = 9'd20;
    localparam logic [8:0] STAGE2_X = 9'd20;
    localparam logic [8:0] STAGE2_Y = 9'd40;
    localparam logic [8:0] STAGE3_X = 9'd40;
    localparam logic [8:0] STAGE3_Y = 9'd20;

    typedef struct packed {
        logic [8:0] x;
        logic [8:0] y;
    } coord_t;

    function automatic logic is_play(input logic [3:0] st);
        return (st == ST_STAGE1) || (st == ST_STAGE2) || (st == ST_STAGE3);
    endfunction

    // Play states map to their own spawn; other states to the stage that comes next.
    function automatic coord_t spawn_for(input logic [3:0] st);
        coord_t c;
        case (st)
            ST_STAGE2, ST_SUCCESS1: c = '{x: STAGE2_X, y: STAGE2_Y};
            ST_STAGE3, ST_SUCCESS2: c = '{x: STAGE3_X, y: STAGE3_Y};
            default:                c = '{x: STAGE1_X, y: STAGE1_Y};
        endcase
        return c;
    endfunction

endpackage

// File: rtl/anim_counter.sv
// Walk-animation divider: counts frame ticks and advances a 2-bit sprite frame every DIV ticks.
// clear has priority over enable and zeroes both the divider and the frame.
module anim_counter #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       enable,
    output logic [1:0] frame
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            frame <= 2'd0;
        end else if (clear) begin
            cnt   <= '0;
            frame <= 2'd0;
        end else if (enable) begin
            if (cnt == LAST) begin
                cnt   <= '0;
                frame <= frame + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/player_ctrl.sv
// Player position and sprite controller: tile-by-tile grid movement gated by a collision
// query to the map, paced by frame_tick, plus stage spawns and the sticky unlock mask.
module player_ctrl
    import game_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] state,
    input  logic       frame_tick,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    output logic       query_valid,
    output logic [8:0] query_x,
    output logic [8:0] query_y,
    input  logic       query_ready,
    input  logic       query_blocked,
    output logic [8:0] player_x,
    output logic [8:0] player_y,
    output logic [3:0] player_state,
    output logic [3:0] play_valid,
    output logic       moving
);

    localparam logic signed [9:0] TILE_S    = 10'(TILE);
    localparam logic signed [9:0] X_MAX_S   = 10'(X_MAX);
    localparam logic signed [9:0] Y_MAX_S   = 10'(Y_MAX);
    localparam logic [3:0]        LAST_STEP = 4'(TILE - 1);

    move_state_t       fsm;
    dir_t              dir;
    dir_t              key_dir;
    logic [3:0]        move_cnt;
    logic [3:0]        prev_state;
    logic [1:0]        frame;
    coord_t            spawn;
    logic              in_play;
    logic              stage_switch;
    logic              hold_idle;
    logic              any_key;
    logic signed [9:0] tgt_x;
    logic signed [9:0] tgt_y;
    logic              tgt_ok;
    logic              last_step;
    logic              anim_clear;
    logic              anim_enable;

    assign in_play      = is_play(state);
    assign stage_switch = in_play && is_play(prev_state) && (state != prev_state);
    assign hold_idle    = !in_play || stage_switch;
    assign spawn        = spawn_for(state);
    assign any_key      = key_up | key_down | key_left | key_right;

    always_comb begin
        key_dir = DIR_RIGHT;
        if (key_up)
            key_dir = DIR_UP;
        else if (key_down)
            key_dir = DIR_DOWN;
        else if (key_left)
            key_dir = DIR_LEFT;
    end

    // Target is formed one bit wider and signed so moves off the top/left edge go negative.
    always_comb begin
        tgt_x = signed'({1'b0, player_x});
        tgt_y = signed'({1'b0, player_y});
        case (key_dir)
            DIR_UP:    tgt_y = signed'({1'b0, player_y}) - TILE_S;
            DIR_DOWN:  tgt_y = signed'({1'b0, player_y}) + TILE_S;
            DIR_LEFT:  tgt_x = signed'({1'b0, player_x}) - TILE_S;
            DIR_RIGHT: tgt_x = signed'({1'b0, player_x}) + TILE_S;
        endcase
    end

    assign tgt_ok = (tgt_x >= 10'sd0) && (tgt_x <= X_MAX_S) &&
                    (tgt_y >= 10'sd0) && (tgt_y <= Y_MAX_S);

    assign last_step   = (fsm == FSM_MOVE) && frame_tick && (move_cnt == LAST_STEP);
    assign anim_clear  = hold_idle || (fsm != FSM_MOVE) || last_step;
    assign anim_enable = (fsm == FSM_MOVE) && frame_tick;

    anim_counter #(
        .DIV    (ANIM_DIV)
    ) u_anim (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (anim_clear),
        .enable (anim_enable),
        .frame  (frame)
    );

    assign player_state = {dir, frame};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm         <= FSM_IDLE;
            dir         <= DIR_UP;
            move_cnt    <= 4'd0;
            prev_state  <= ST_TITLE;
            player_x    <= STAGE1_X;
            player_y    <= STAGE1_Y;
            query_valid <= 1'b0;
            query_x     <= 9'd0;
            query_y     <= 9'd0;
            moving      <= 1'b0;
            play_valid  <= 4'b0010;
        end else begin
            prev_state <= state;

            if (state == ST_SUCCESS1) play_valid[2] <= 1'b1;
            if (state == ST_SUCCESS2) play_valid[3] <= 1'b1;
            if (state == ST_SUCCESS3) play_valid[0] <= 1'b1;

            // Leaving play or jumping between stages abandons any move and parks at the spawn.
            if (hold_idle) begin
                fsm         <= FSM_IDLE;
                query_valid <= 1'b0;
                moving      <= 1'b0;
                move_cnt    <= 4'd0;
                player_x    <= spawn.x;
                player_y    <= spawn.y;
            end else begin
                case (fsm)
                    FSM_IDLE: begin
                        if (any_key) begin
                            dir <= key_dir;
                            if (tgt_ok) begin
                                query_valid <= 1'b1;
                                query_x     <= tgt_x[8:0];
                                query_y     <= tgt_y[8:0];
                                fsm         <= FSM_QUERY;
                            end
                        end
                    end
                    FSM_QUERY: begin
                        if (query_ready) begin
                            query_valid <= 1'b0;
                            if (query_blocked) begin
                                fsm <= FSM_IDLE;
                            end else begin
                                fsm      <= FSM_MOVE;
                                move_cnt <= 4'd0;
                                moving   <= 1'b1;
                            end
                        end
                    end
                    FSM_MOVE: begin
                        if (frame_tick) begin
                            case (dir)
                                DIR_UP:    player_y <= player_y - 9'd1;
                                DIR_DOWN:  player_y <= player_y + 9'd1;
                                DIR_LEFT:  player_x <= player_x - 9'd1;
                                DIR_RIGHT: player_x <= player_x + 9'd1;
                            endcase
                            if (move_cnt == LAST_STEP) begin
                                fsm      <= FSM_IDLE;
                                moving   <= 1'b0;
                                move_cnt <= 4'd0;
                            end else begin
                                move_cnt <= move_cnt + 4'd1;
                            end
                        end
                    end
                    default: fsm <= FSM_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_player_ctrl.sv
// Scoreboard bench for player_ctrl: expected queries and move completions are queued by
// the stimulus; a monitor pops them when query_valid rises or moving falls.
module tb_player_ctrl;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] state;
    logic       frame_tick;
    logic       key_up, key_down, key_left, key_right;
    logic       query_valid;
    logic [8:0] query_x, query_y;
    logic       query_ready, query_blocked;
    logic [8:0] player_x, player_y;
    logic [3:0] player_state;
    logic [3:0] play_valid;
    logic       moving;

    always #5 clk = ~clk;

    player_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .state         (state),
        .frame_tick    (frame_tick),
        .key_up        (key_up),
        .key_down      (key_down),
        .key_left      (key_left),
        .key_right     (key_right),
        .query_valid   (query_valid),
        .query_x       (query_x),
        .query_y       (query_y),
        .query_ready   (query_ready),
        .query_blocked (query_blocked),
        .player_x      (player_x),
        .player_y      (player_y),
        .player_state  (player_state),
        .play_valid    (play_valid),
        .moving        (moving)
    );

    typedef struct {
        logic [8:0] x;
        logic [8:0] y;
        logic [3:0] ps;
    } exp_t;

    localparam logic [3:0] K_UP    = 4'b1000;
    localparam logic [3:0] K_DOWN  = 4'b0100;
    localparam logic [3:0] K_LEFT  = 4'b0010;
    localparam logic [3:0] K_RIGHT = 4'b0001;

    exp_t q_query[$];
    exp_t q_done[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        total_cnt++;
        if (actual === expected)
            pass_cnt++;
        else
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [3:0] keys, input logic tick);
        {key_up, key_down, key_left, key_right} = keys;
        frame_tick = tick;
    endtask

    task automatic startMove(input logic [3:0] keys, input logic [8:0] qx,
                             input logic [8:0] qy, input logic blocked);
        exp_t e;
        e.x = qx; e.y = qy; e.ps = 4'd0;
        q_query.push_back(e);
        applyStimulus(keys, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b0);
        query_ready   = 1'b1;
        query_blocked = blocked;
        step();
        query_ready   = 1'b0;
        query_blocked = 1'b0;
    endtask

    task automatic runTicks(input int n);
        frame_tick = 1'b1;
        repeat (n) step();
        frame_tick = 1'b0;
    endtask

    task automatic pushDone(input logic [8:0] x, input logic [8:0] y, input logic [3:0] ps);
        exp_t e;
        e.x = x; e.y = y; e.ps = ps;
        q_done.push_back(e);
    endtask

    task automatic moveTile(input logic [3:0] keys, input logic [8:0] qx,
                            input logic [8:0] qy, input logic [3:0] ps);
        startMove(keys, qx, qy, 1'b0);
        pushDone(qx, qy, ps);
        runTicks(10);
    endtask

    // Monitor: new query requests and finished/aborted moves are checked against the queues.
    initial begin
        logic prev_qv;
        logic prev_mv;
        exp_t e;
        prev_qv = 1'b0;
        prev_mv = 1'b0;
        forever begin
            @(negedge clk);
            if (query_valid && !prev_qv) begin
                if (q_query.size() == 0) begin
                    total_cnt++;
                    $display("[TB] FAIL unexpected_query: got (%0d,%0d), expected none",
                             query_x, query_y);
                end else begin
                    e = q_query.pop_front();
                    checkOutput("query_x", 16'(query_x), 16'(e.x));
                    checkOutput("query_y", 16'(query_y), 16'(e.y));
                end
            end
            if (!moving && prev_mv) begin
                if (q_done.size() == 0) begin
                    total_cnt++;
                    $display("[TB] FAIL unexpected_move_end: got (%0d,%0d), expected none",
                             player_x, player_y);
                end else begin
                    e = q_done.pop_front();
                    checkOutput("done_x", 16'(player_x), 16'(e.x));
                    checkOutput("done_y", 16'(player_y), 16'(e.y));
                    checkOutput("done_state", 16'(player_state), 16'(e.ps));
                end
            end
            prev_qv = query_valid;
            prev_mv = moving;
        end
    end

    initial begin
        int exp_frame;
        rst_n         = 1'b0;
        state         = ST_STAGE1;
        query_ready   = 1'b0;
        query_blocked = 1'b0;
        applyStimulus(4'b0000, 1'b0);
        repeat (2) @(negedge clk);

        checkOutput("rst_x", 16'(player_x), 16'd20);
        checkOutput("rst_y", 16'(player_y), 16'd20);
        checkOutput("rst_state", 16'(player_state), 16'd0);
        checkOutput("rst_play_valid", 16'(play_valid), 16'd2);
        checkOutput("rst_query_valid", 16'(query_valid), 16'd0);
        rst_n = 1'b1;
        step();
        checkOutput("rel_x", 16'(player_x), 16'd20);
        checkOutput("rel_y", 16'(player_y), 16'd20);
        checkOutput("rel_moving", 16'(moving), 16'd0);

        // Right move with a delayed map response, watching the walk frames tick by tick.
        q_query.push_back('{x: 9'd30, y: 9'd20, ps: 4'd0});
        applyStimulus(K_RIGHT, 1'b0);
        step();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("right_dir", 16'(player_state), 16'b1100);
        checkOutput("right_qv", 16'(query_valid), 16'd1);
        repeat (3) begin
            step();
            checkOutput("hold_qv", 16'(query_valid), 16'd1);
            checkOutput("hold_qx", 16'(query_x), 16'd30);
        end
        query_ready = 1'b1;
        step();
        query_ready = 1'b0;
        checkOutput("move_start", 16'(moving), 16'd1);
        checkOutput("move_start_x", 16'(player_x), 16'd20);
        pushDone(9'd30, 9'd20, 4'b1100);
        frame_tick = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            step();
            exp_frame = (i == 10) ? 0 : i / 4;
            checkOutput("walk_x", 16'(player_x), 16'(20 + i));
            checkOutput("walk_state", 16'(player_state), 16'({2'b11, 2'(exp_frame)}));
            checkOutput("walk_moving", 16'(moving), (i < 10) ? 16'd1 : 16'd0);
        end
        frame_tick = 1'b0;

        // Blocked up move leaves the position alone but still turns the sprite.
        startMove(K_UP, 9'd30, 9'd10, 1'b1);
        checkOutput("blk_x", 16'(player_x), 16'd30);
        checkOutput("blk_y", 16'(player_y), 16'd20);
        checkOutput("blk_state", 16'(player_state), 16'd0);
        checkOutput("blk_qv", 16'(query_valid), 16'd0);
        checkOutput("blk_moving", 16'(moving), 16'd0);

        moveTile(K_UP, 9'd30, 9'd10, 4'b0000);
        moveTile(K_UP, 9'd30, 9'd0, 4'b0000);

        // At the top edge an up key must not produce any query.
        applyStimulus(K_UP, 1'b0);
        repeat (3) step();
        applyStimulus(4'b0000, 1'b0);
        checkOutput("edge_qv", 16'(query_valid), 16'd0);
        checkOutput("edge_y", 16'(player_y), 16'd0);

        moveTile(K_DOWN, 9'd30, 9'd10, 4'b0100);
        startMove(K_UP | K_LEFT, 9'd30, 9'd0, 1'b1);
        checkOutput("prio_state", 16'(player_state), 16'd0);
        checkOutput("prio_x", 16'(player_x), 16'd30);

        // Stage change on a tick mid-move: spawn load wins, no step.
        startMove(K_RIGHT, 9'd40, 9'd10, 1'b0);
        runTicks(5);
        checkOutput("mid_x", 16'(player_x), 16'd35);
        pushDone(9'd20, 9'd40, 4'b1100);
        state      = ST_SUCCESS1;
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
        checkOutput("s1_x", 16'(player_x), 16'd20);
        checkOutput("s1_y", 16'(player_y), 16'd40);
        checkOutput("s1_moving", 16'(moving), 16'd0);
        checkOutput("s1_pv", 16'(play_valid), 16'b0110);
        state = ST_SUCCESS2;
        step();
        checkOutput("s2_pv", 16'(play_valid), 16'b1110);
        checkOutput("s2_x", 16'(player_x), 16'd40);
        checkOutput("s2_y", 16'(player_y), 16'd20);
        state = ST_SUCCESS3;
        step();
        checkOutput("s3_pv", 16'(play_valid), 16'b1111);
        checkOutput("s3_y", 16'(player_y), 16'd20);
        state = ST_STAGE1;
        step();
        state = ST_STAGE2;
        step();
        checkOutput("switch_x", 16'(player_x), 16'd20);
        checkOutput("switch_y", 16'(player_y), 16'd40);

        // Asynchronous reset between clock edges during a move.
        startMove(K_RIGHT, 9'd30, 9'd40, 1'b0);
        pushDone(9'd20, 9'd20, 4'b0000);
        runTicks(3);
        checkOutput("pre_rst_x", 16'(player_x), 16'd23);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("arst_x", 16'(player_x), 16'd20);
        checkOutput("arst_y", 16'(player_y), 16'd20);
        checkOutput("arst_moving", 16'(moving), 16'd0);
        checkOutput("arst_state", 16'(player_state), 16'd0);
        checkOutput("arst_pv", 16'(play_valid), 16'd2);
        checkOutput("arst_qx", 16'(query_x), 16'd0);
        @(negedge clk);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();

        checkOutput("query_q_empty", 16'(q_query.size()), 16'd0);
        checkOutput("done_q_empty", 16'(q_done.size()), 16'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
